gb_capture_ctrl: RTL
====================

# gb_capture_ctrl

Capture sequencer between the Game Boy LCD pins and the dual-bank 2 bpp framebuffer RAM. It synchronises the GB pixel clock, HSYNC, VSYNC and data into the 25 MHz VGA domain, tracks the GB raster position, and produces the framebuffer write address, data and enable. It also double-buffers the frame: the write bank and read bank swap only when a frame is complete and the VGA side is in vertical blanking, so the scanout never tears.

## Interface
- `H_PIXELS`, 160: GB pixels per line.
- `V_PIXELS`, 144: GB lines per frame.
- `ADDR_WIDTH`, 15: per-bank offset width; requires H_PIXELS*V_PIXELS ≤ 2^ADDR_WIDTH.

- `clk`  in  1  25 MHz VGA pixel clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `gb_px_clk`  in  1  raw GB pixel clock; data is valid at its falling edge.
- `gb_hsync`  in  1  raw GB HSYNC; a rising edge starts a line.
- `gb_vsync`  in  1  raw GB VSYNC; a rising edge starts a frame.
- `gb_dat`  in  2  raw GB pixel data.
- `enable`  in  1  capture enable, sampled only in IDLE.
- `vga_vblank`  in  1  level, high while VGA is outside the active rows.
- `fb_waddr`  out  ADDR_WIDTH+1  {wr_bank, offset}.
- `fb_wdata`  out  2  pixel to write.
- `fb_we`  out  1  single-cycle write strobe.
- `wr_bank`  out  1  bank being written.
- `rd_bank`  out  1  bank for VGA to read; always equals ~wr_bank.
- `frame_done`  out  1  1-cycle pulse when a complete frame is written.
- `frame_err`  out  1  1-cycle pulse when a frame is aborted.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Synchronisers**
  - `gb_px_clk`, `gb_hsync`, `gb_vsync` and `gb_dat` each pass through 2 flops, then a 3rd history flop. All reset to 0.
  - A falling edge of the pixel clock is s2=0 and s3=1. A rising edge of HSYNC or VSYNC is s2=1 and s3=0.
  - Edge detection is suppressed for 3 cycles after reset release, so no spurious edges are seen.
  - Pixel data is taken from the synced s2 stage, so it stays aligned with the pixel clock.
- **Counters**
  - `x` counts 0..H_PIXELS. `y` counts 0..V_PIXELS-1.
  - `base` equals y*H_PIXELS, built by accumulating +H_PIXELS. No multiplier.
  - The write offset is base+x, truncated to ADDR_WIDTH bits.
- **FSM** (states IDLE, LINE_WAIT, CAPTURE):
  - **IDLE**
    - On vsync↑ with `enable`=1 and no swap pending: set y=0 and base=0.
    - If hsync↑ occurs in the same cycle, go to CAPTURE with x=0. Otherwise go to LINE_WAIT.
  - **LINE_WAIT**
    - On hsync↑: set x=0 and go to CAPTURE.
    - Pixel-clock edges are ignored.
  - **CAPTURE**
    - On each px↓ with x<H_PIXELS: write, then x++.
    - When x reaches H_PIXELS on a line with y<V_PIXELS-1: y++, base+=H_PIXELS, go to LINE_WAIT.
    - When x reaches H_PIXELS on line y=V_PIXELS-1: pulse `frame_done`, set swap pending, go to IDLE.
  - **Short line**: hsync↑ in CAPTURE with x<H_PIXELS pulses `frame_err` and goes to IDLE. No swap.
  - **Early VSYNC**: vsync↑ in LINE_WAIT or CAPTURE (not IDLE) pulses `frame_err` and restarts at y=0, base=0.
    - The next state is LINE_WAIT, or CAPTURE if hsync↑ occurs in the same cycle.
  - **Priority**: vsync↑ beats hsync↑, and hsync↑ beats px↓ in the same cycle.
- **Bank swap**
  - When swap pending and `vga_vblank`=1: toggle `wr_bank`, invert `rd_bank`, clear pending.
  - While a swap is pending, IDLE does not start a new frame. That frame is skipped.
- **Enable**: deasserting `enable` mid-frame does not abort; the current frame completes.

## Timing
- **Reset values**
  - Outputs: fb_we=0, fb_waddr=0, fb_wdata=0, wr_bank=0, rd_bank=1, frame_done=0, frame_err=0, busy=0.
  - Internal: state=IDLE, swap pending=0.
- **Outputs are registered**: fb_we, fb_waddr and fb_wdata change together.
- **Pixel latency**: a pin px↓ first sampled at clk edge k produces fb_we=1 after edge k+2, high for exactly 1 cycle.
- **Write spacing**: at least 2 cycles between writes.
- **Pixel-clock limit**: GB pixel clock ≤ 6.25 MHz (each level ≥ 2 clk).
- **Pulse timing**:
  - `frame_done` is asserted in the same cycle as the last `fb_we`.
  - `frame_err` is asserted 1 cycle after the offending edge is detected.
- **Swap latency**: earliest swap is the cycle after `frame_done`. If `vga_vblank` is already high, the swap happens then.
- **Reset mid-frame**: immediate return to reset values; no partial swap.

## Test plan
- **Full frame**: reset → vsync↑, then 144×(hsync↑ + 160 px↓), gb_dat=(x+y)%4, vga_vblank=1.
  - Exactly 23040 writes; offsets 0..23039 with the correct data.
  - `frame_done` pulses once; wr_bank becomes 1, rd_bank becomes 0.
- **Short line**: line 5 has 100 px↓, then hsync↑.
  - `frame_err` pulses; last offset written is 5*160+99=899; state returns to IDLE; banks unchanged.
- **Early VSYNC**: vsync↑ during line 70.
  - `frame_err` pulses; the next write lands at offset 0 (line 0 restarts); banks unchanged.
- **Swap deferral**: complete a frame with vga_vblank=0 for 1000 cycles, then raise it.
  - wr_bank stays 0 until the cycle after vblank rises, then toggles.
  - A vsync↑ during the deferral is ignored (no writes, busy=0).
- **Enable**: enable=0 at vsync↑ → no writes. Enable dropped during line 10 → frame still completes with `frame_done`.
- **Reset mid-frame**: assert rst during line 50.
  - All outputs go to reset values asynchronously.
  - gb_vsync held high at reset release produces no frame start.

Source files
------------

// File: rtl/gb_capture_ctrl.sv
// Samples the Game Boy LCD pins in the VGA clock domain and writes each pixel into a double-buffered 2 bpp framebuffer.
// A pixel is written 2 clk after its falling pixel-clock edge is first sampled; banks swap only after a full frame, during VGA vblank.
module gb_capture_ctrl #(
   parameter int H_PIXELS   = 160,
   parameter int V_PIXELS   = 144,
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  gb_px_clk,
   input  logic                  gb_hsync,
   input  logic                  gb_vsync,
   input  logic [1:0]            gb_dat,
   input  logic                  enable,
   input  logic                  vga_vblank,
   output logic [ADDR_WIDTH:0]   fb_waddr,
   output logic [1:0]            fb_wdata,
   output logic                  fb_we,
   output logic                  wr_bank,
   output logic                  rd_bank,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic                  busy
);
   localparam int XW = $clog2(H_PIXELS + 1);
   localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
   localparam logic [XW-1:0]         X_LAST    = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0]         Y_LAST    = YW'(V_PIXELS - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_PIXELS);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] LINE_WAIT = 2'd1;
   localparam logic [1:0] CAPTURE   = 2'd2;

   // Bit 0 is the first sync flop, bit 1 the second, bit 2 the edge-history flop.
   logic [2:0] px_sync, hs_sync, vs_sync;
   logic [1:0] dat_s1, dat_s2;
   logic [1:0] arm_cnt;
   logic       edges_on, px_fall, hs_rise, vs_rise;

   logic [1:0]            state;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic [ADDR_WIDTH-1:0] base, offset;
   logic                  swap_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         px_sync <= '0;
         hs_sync <= '0;
         vs_sync <= '0;
         dat_s1  <= '0;
         dat_s2  <= '0;
         arm_cnt <= '0;
      end else begin
         px_sync <= {px_sync[1:0], gb_px_clk};
         hs_sync <= {hs_sync[1:0], gb_hsync};
         vs_sync <= {vs_sync[1:0], gb_vsync};
         dat_s1  <= gb_dat;
         dat_s2  <= dat_s1;
         if (arm_cnt != 2'd3)
            arm_cnt <= arm_cnt + 2'd1;
      end
   end

   // Pins already high at reset release would otherwise look like rising edges.
   assign edges_on = (arm_cnt == 2'd3);
   assign px_fall  = edges_on & ~px_sync[1] &  px_sync[2];
   assign hs_rise  = edges_on &  hs_sync[1] & ~hs_sync[2];
   assign vs_rise  = edges_on &  vs_sync[1] & ~vs_sync[2];

   assign offset  = base + ADDR_WIDTH'(x);
   assign busy    = (state != IDLE);
   assign rd_bank = ~wr_bank;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         x          <= '0;
         y          <= '0;
         base       <= '0;
         swap_pend  <= 1'b0;
         wr_bank    <= 1'b0;
         fb_we      <= 1'b0;
         fb_waddr   <= '0;
         fb_wdata   <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         fb_we      <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         if (swap_pend && vga_vblank) begin
            wr_bank   <= ~wr_bank;
            swap_pend <= 1'b0;
         end

         case (state)
            IDLE: begin
               // A finished frame still waiting for its swap blocks the next one.
               if (vs_rise && enable && !swap_pend) begin
                  x     <= '0;
                  y     <= '0;
                  base  <= '0;
                  state <= hs_rise ? CAPTURE : LINE_WAIT;
               end
            end
            LINE_WAIT, CAPTURE: begin
               if (vs_rise) begin
                  frame_err <= 1'b1;
                  x         <= '0;
                  y         <= '0;
                  base      <= '0;
                  state     <= hs_rise ? CAPTURE : LINE_WAIT;
               end else if (hs_rise) begin
                  x <= '0;
                  if (state == CAPTURE) begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     state <= CAPTURE;
                  end
               end else if (px_fall && state == CAPTURE && x <= X_LAST) begin
                  fb_we    <= 1'b1;
                  fb_waddr <= {wr_bank, offset};
                  fb_wdata <= dat_s2;
                  x        <= x + 1'b1;
                  if (x == X_LAST) begin
                     if (y == Y_LAST) begin
                        frame_done <= 1'b1;
                        swap_pend  <= 1'b1;
                        state      <= IDLE;
                     end else begin
                        y     <= y + 1'b1;
                        base  <= base + LINE_STEP;
                        state <= LINE_WAIT;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
